// File: rtl/qspi_mem_responder.sv
// QSPI target memory: oversamples the bus on clk and serves quad reads/writes.
// Define QSPI_RESP_CONT_READ_EN to enable the 0xEB mode byte and continuous-read mode.
module qspi_mem_responder #(
    parameter int    ADDR_W       = 16,
    parameter int    DUMMY_CYCLES = 4,
    parameter string INIT_FILE    = ""
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_clk_in,
    input  logic       spi_cs_n_in,
    input  logic [3:0] spi_d_in,
    output logic [3:0] spi_d_out,
    output logic       spi_d_oe,
    output logic       busy
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CMD   = 3'd1;
    localparam logic [2:0] ST_ADDR  = 3'd2;
    localparam logic [2:0] ST_MODE  = 3'd3;
    localparam logic [2:0] ST_DUMMY = 3'd4;
    localparam logic [2:0] ST_READ  = 3'd5;
    localparam logic [2:0] ST_WRITE = 3'd6;
    localparam logic [2:0] ST_IGN   = 3'd7;

    localparam logic [7:0] DUMMY_N = 8'(DUMMY_CYCLES);

    logic [7:0] mem_q [0:(1<<ADDR_W)-1];

    logic [2:0]        sclk_s_q;
    logic [1:0]        cs_s_q;
    logic [3:0]        d_s1_q, d_s2_q;

    logic [2:0]        st_q, st_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [23:0]       sh_q, sh_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_q, wr_d;
    logic              nib_q, nib_d;
    logic [3:0]        wbuf_q, wbuf_d;
    logic [3:0]        dout_q, dout_d;
    logic              oe_q, oe_d;
    logic              cont_q, cont_d;
    logic [7:0]        rd_q;
    logic              we;
    logic [7:0]        wdata;

    logic        rise, fall, cs_hi;
    logic [23:0] sh_nx;

    assign rise  = sclk_s_q[1] & ~sclk_s_q[2];
    assign fall  = ~sclk_s_q[1] & sclk_s_q[2];
    assign cs_hi = cs_s_q[1];
    assign sh_nx = {sh_q[19:0], d_s2_q};

    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q;
        sh_d   = sh_q;
        addr_d = addr_q;
        wr_d   = wr_q;
        nib_d  = nib_q;
        wbuf_d = wbuf_q;
        dout_d = dout_q;
        oe_d   = oe_q;
        cont_d = cont_q;
        we     = 1'b0;
        wdata  = {wbuf_q, d_s2_q};
        if (cs_hi) begin
            // CS deassertion wins over any edge seen on the same clk
            st_d  = ST_IDLE;
            oe_d  = 1'b0;
            cnt_d = '0;
            nib_d = 1'b0;
        end else begin
            unique case (st_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    nib_d = 1'b0;
                    if (cont_q) begin
                        st_d = ST_ADDR;
                        wr_d = 1'b0;
                    end else begin
                        st_d = ST_CMD;
                    end
                end
                ST_CMD: if (rise) begin
                    sh_d  = sh_nx;
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == 8'd1) begin
                        cnt_d = '0;
                        unique case (1'b1)
                            sh_nx[7:0] == 8'hEB: begin
                                st_d = ST_ADDR;
                                wr_d = 1'b0;
                            end
                            sh_nx[7:0] == 8'h38,
                            sh_nx[7:0] == 8'h02: begin
                                st_d = ST_ADDR;
                                wr_d = 1'b1;
                            end
                            default: st_d = ST_IGN;
                        endcase
                    end
                end
                ST_ADDR: if (rise) begin
                    sh_d  = sh_nx;
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == 8'd5) begin
                        cnt_d  = '0;
                        addr_d = sh_nx[ADDR_W-1:0];
`ifdef QSPI_RESP_CONT_READ_EN
                        st_d   = wr_q ? ST_WRITE : ST_MODE;
`else
                        st_d   = wr_q ? ST_WRITE : ST_DUMMY;
`endif
                    end
                end
                ST_MODE: if (rise) begin
                    sh_d  = sh_nx;
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == 8'd1) begin
                        cnt_d  = '0;
                        st_d   = ST_DUMMY;
`ifdef QSPI_RESP_CONT_READ_EN
                        cont_d = (sh_nx[7:4] == 4'hA);
`endif
                    end
                end
                ST_DUMMY: begin
                    if (rise && cnt_q != DUMMY_N)
                        cnt_d = cnt_q + 8'd1;
                    if (fall && cnt_q == DUMMY_N) begin
                        dout_d = rd_q[7:4];
                        oe_d   = 1'b1;
                        nib_d  = 1'b1;
                        st_d   = ST_READ;
                    end
                end
                ST_READ: if (fall) begin
                    if (nib_q) begin
                        dout_d = rd_q[3:0];
                        addr_d = addr_q + 1'b1;
                        nib_d  = 1'b0;
                    end else begin
                        dout_d = rd_q[7:4];
                        nib_d  = 1'b1;
                    end
                end
                ST_WRITE: if (rise) begin
                    if (nib_q) begin
                        we     = 1'b1;
                        addr_d = addr_q + 1'b1;
                        nib_d  = 1'b0;
                    end else begin
                        wbuf_d = d_s2_q;
                        nib_d  = 1'b1;
                    end
                end
                ST_IGN: ;
                default: st_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_s_q <= '0;
            cs_s_q   <= 2'b11;
            d_s1_q   <= '0;
            d_s2_q   <= '0;
            st_q     <= ST_IDLE;
            cnt_q    <= '0;
            sh_q     <= '0;
            addr_q   <= '0;
            wr_q     <= 1'b0;
            nib_q    <= 1'b0;
            wbuf_q   <= '0;
            dout_q   <= '0;
            oe_q     <= 1'b0;
            cont_q   <= 1'b0;
        end else begin
            sclk_s_q <= {sclk_s_q[1:0], spi_clk_in};
            cs_s_q   <= {cs_s_q[0], spi_cs_n_in};
            d_s1_q   <= spi_d_in;
            d_s2_q   <= d_s1_q;
            st_q     <= st_d;
            cnt_q    <= cnt_d;
            sh_q     <= sh_d;
            addr_q   <= addr_d;
            wr_q     <= wr_d;
            nib_q    <= nib_d;
            wbuf_q   <= wbuf_d;
            dout_q   <= dout_d;
            oe_q     <= oe_d;
            cont_q   <= cont_d;
        end
    end

    // Registered array port; refetches every clk so the byte is ready before the next fall
    always_ff @(posedge clk) begin
        if (we)
            mem_q[addr_q] <= wdata;
        rd_q <= mem_q[addr_q];
    end

    assign spi_d_out = dout_q;
    assign spi_d_oe  = oe_q;
    assign busy      = (st_q != ST_IDLE);

endmodule
